ultrasonic_sensor_emulator: RTL and testbench

- Synthesizable responder for the ultrasonic-ranging interface: accepts the trigger pulse from the game's distance-measurement path and answers with an echo pulse proportional to a programmed distance, exactly as an HC-SR04 would.
- Used in benches and on-board self-test to drive the delivery game's velocity input without the physical sensor.
- Single clock domain; the trigger input passes through a 2-flop synchronizer.

---
 rtl/ultrasonic_sensor_emulator_pkg.sv | 42 ++++
 rtl/ultrasonic_sensor_emulator_us_tick_counter.sv | 42 ++++
 rtl/ultrasonic_sensor_emulator.sv | 177 +++++++++++++++++
 tb/tb_ultrasonic_sensor_emulator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_sensor_emulator_pkg.sv
// Shared types, widths and helpers for the ultrasonic (HC-SR04 style) sensor emulator.
package sensor_emulator_pkg;

    localparam int US_W    = 16;
    localparam int DIST_W  = 9;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        MEDE_TRIG = 3'd1,
        BURST     = 3'd2,
        ECHO      = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    localparam logic [DIST_W-1:0] MIN_CM    = 9'd2;
    localparam logic [7:0]        LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 of a Fibonacci LFSR, bit 7 being tap 8.
    localparam logic [7:0]        LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

    function automatic logic [US_W-1:0] echo_us(input logic [DIST_W-1:0] d,
                                                 input logic [US_W-1:0]   per_cm,
                                                 input logic [US_W-1:0]   max_cm,
                                                 input logic [US_W-1:0]   timeout);
        logic [US_W-1:0] dc;
        logic [US_W-1:0] w;
        dc = {{(US_W-DIST_W){1'b0}}, d};
        if (d < MIN_CM) begin
            w = timeout;
        end else if (dc > max_cm) begin
            w = max_cm * per_cm;
        end else begin
            w = dc * per_cm;
        end
        return w;
    endfunction

endpackage

// File: rtl/ultrasonic_sensor_emulator_us_tick_counter.sv
// Microsecond prescaler plus 16-bit microsecond counter shared by all timed states.
module us_tick_counter
    import sensor_emulator_pkg::*;
#(
    parameter int CYCLES_PER_US = 50
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    output logic            tick,
    output logic [US_W-1:0] count
);

    localparam int            PW         = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_US - 1);

    logic [PW-1:0] presc_r;

    // tick marks the last cycle of the current microsecond.
    assign tick = (presc_r == PRESC_LAST);

    // Prescaler wraps into the microsecond counter; clear wins over enable.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            presc_r <= '0;
            count   <= '0;
        end else if (enable) begin
            if (tick) begin
                presc_r <= '0;
                count   <= count + 16'd1;
            end else begin
                presc_r <= presc_r + PW'(1);
                count   <= count;
            end
        end else begin
            presc_r <= presc_r;
            count   <= count;
        end
    end

endmodule

// File: rtl/ultrasonic_sensor_emulator.sv
// HC-SR04 style responder: trigger in, distance-proportional echo out.
// Optional macro SENSOR_JITTER_EN adds 0..7 us of LFSR jitter to each echo.
module ultrasonic_sensor_emulator
    import sensor_emulator_pkg::*;
#(
    parameter int CYCLES_PER_US = 50,
    parameter int TRIG_MIN_US   = 10,
    parameter int BURST_US      = 200,
    parameter int US_PER_CM     = 58,
    parameter int MAX_CM        = 400,
    parameter int TIMEOUT_US    = 38000,
    parameter int HOLDOFF_US    = 1000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              trigger,
    input  logic [DIST_W-1:0] distancia,
    output logic              echo,
    output logic              busy,
    output logic              pronto,
    output logic              rejeitado,
    output logic [STATE_W-1:0] db_estado
);

    localparam logic [US_W-1:0] TRIG_MIN   = US_W'(TRIG_MIN_US);
    localparam logic [US_W-1:0] BURST_LAST = US_W'(BURST_US - 1);
    localparam logic [US_W-1:0] HOLD_LAST  = US_W'(HOLDOFF_US - 1);
    localparam logic [US_W-1:0] PER_CM     = US_W'(US_PER_CM);
    localparam logic [US_W-1:0] MAX_D      = US_W'(MAX_CM);
    localparam logic [US_W-1:0] TIMEOUT    = US_W'(TIMEOUT_US);

    state_t          state_r;
    logic            sync_r;
    logic            trig_s;
    logic            trig_d;
    logic [US_W-1:0] w_r;
    logic [US_W-1:0] width_s;
    logic [US_W-1:0] count_s;
    logic            tick_s;
    logic            clear_s;
    logic            tmr_en_s;
    logic            accept_s;

    assign db_estado = state_r;
    assign accept_s  = (state_r == MEDE_TRIG) && !trig_s && (count_s >= TRIG_MIN);

    // Two-flop synchronizer plus one delayed copy for rising-edge qualification.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_r <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
        end else begin
            sync_r <= trigger;
            trig_s <= sync_r;
            trig_d <= trig_s;
        end
    end

`ifdef SENSOR_JITTER_EN
    logic [7:0] lfsr_r;

    // Jitter source advances once per accepted trigger.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_r <= LFSR_SEED;
        end else if (accept_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    // Echo width in microseconds for the distance presented right now.
    always_comb begin
        width_s = echo_us(distancia, PER_CM, MAX_D, TIMEOUT);
`ifdef SENSOR_JITTER_EN
        width_s = width_s + {13'd0, lfsr_r[2:0]};
`endif
    end

    // clear_s doubles as "leaving this state", so every entry starts the timer at zero.
    always_comb begin
        clear_s  = 1'b1;
        tmr_en_s = !((state_r == MEDE_TRIG) && (count_s >= TRIG_MIN));
        case (state_r)
            IDLE:      clear_s = 1'b1;
            MEDE_TRIG: clear_s = !trig_s;
            BURST:     clear_s = tick_s && (count_s == BURST_LAST);
            ECHO:      clear_s = tick_s && (count_s == w_r - 16'd1);
            HOLDOFF:   clear_s = tick_s && (count_s == HOLD_LAST);
            default:   clear_s = 1'b1;
        endcase
    end

    us_tick_counter #(
        .CYCLES_PER_US(CYCLES_PER_US)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear_s),
        .enable (tmr_en_s),
        .tick   (tick_s),
        .count  (count_s)
    );

    // Main sequencer with registered echo/busy/pronto/rejeitado.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            echo      <= 1'b0;
            busy      <= 1'b0;
            pronto    <= 1'b0;
            rejeitado <= 1'b0;
            w_r       <= 16'd0;
        end else begin
            pronto    <= 1'b0;
            rejeitado <= 1'b0;
            case (state_r)
                IDLE: begin
                    echo <= 1'b0;
                    if (enable && trig_s && !trig_d) begin
                        state_r <= MEDE_TRIG;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                MEDE_TRIG: begin
                    if (accept_s) begin
                        w_r     <= width_s;
                        state_r <= BURST;
                    end else if (!trig_s) begin
                        rejeitado <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= MEDE_TRIG;
                    end
                end
                BURST: begin
                    if (clear_s) begin
                        echo    <= 1'b1;
                        state_r <= ECHO;
                    end else begin
                        state_r <= BURST;
                    end
                end
                ECHO: begin
                    if (clear_s) begin
                        echo    <= 1'b0;
                        state_r <= HOLDOFF;
                    end else begin
                        state_r <= ECHO;
                    end
                end
                HOLDOFF: begin
                    if (clear_s) begin
                        pronto  <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLDOFF;
                    end
                end
                default: begin
                    echo    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_sensor_emulator.sv
// Self-checking bench: per-cycle comparison against an event-time model of the sensor.
module tb_ultrasonic_sensor_emulator;

    localparam int CPU  = 2;
    localparam int TMIN = 4;
    localparam int BUS  = 20;
    localparam int UPC  = 3;
    localparam int MAXC = 40;
    localparam int TOUT = 150;
    localparam int HOLD = 30;
    localparam int NB   = BUS * CPU;
    localparam int NH   = HOLD * CPU;
    localparam int THR  = TMIN * CPU;
    localparam int BIG  = 1 << 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       trigger;
    logic [8:0] distancia;
    logic       echo;
    logic       busy;
    logic       pronto;
    logic       rejeitado;
    logic [2:0] db_estado;

    ultrasonic_sensor_emulator #(
        .CYCLES_PER_US(CPU), .TRIG_MIN_US(TMIN), .BURST_US(BUS), .US_PER_CM(UPC),
        .MAX_CM(MAXC), .TIMEOUT_US(TOUT), .HOLDOFF_US(HOLD)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .trigger(trigger),
        .distancia(distancia), .echo(echo), .busy(busy), .pronto(pronto),
        .rejeitado(rejeitado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the current measurement, expressed as event times in clock edges.
    bit ep_valid = 1'b0;
    bit ep_acc   = 1'b0;
    int ep_r0    = 0;
    int ep_f0    = BIG;
    int ep_wc    = 0;
    int ep_abort = BIG;
    int f0_last  = 0;
    bit chk_on   = 1'b0;
`ifdef SENSOR_JITTER_EN
    logic [7:0] m_lfsr = 8'hA5;
`endif

    int   rise_c = 0;
    int   fall_c = 0;
    int   pr_c   = 0;
    int   rj_c   = 0;
    logic echo_q = 1'b0;

    function automatic int w_us(input int d, input int jit);
        if (d < 2) return TOUT + jit;
        return ((d > MAXC) ? MAXC : d) * UPC + jit;
    endfunction

    function automatic logic [6:0] expect_at(input int c);
        logic [2:0] db;
        logic b, ec, pn, rj;
        int e, fe, pr;
        db = 3'd0; b = 1'b0; ec = 1'b0; pn = 1'b0; rj = 1'b0;
        if (ep_valid && c < ep_abort && c >= ep_r0 + 2) begin
            if (c < ep_f0 + 2) begin
                db = 3'd1; b = 1'b1;
            end else if (!ep_acc) begin
                rj = (c == ep_f0 + 2);
            end else begin
                e  = ep_f0 + 2 + NB;
                fe = e + ep_wc;
                pr = fe + NH;
                if (c < e)       db = 3'd2;
                else if (c < fe) db = 3'd3;
                else if (c < pr) db = 3'd4;
                b  = (c < pr);
                ec = (c >= e) && (c < fe);
                pn = (c == pr);
            end
        end
        return {db, b, ec, pn, rj};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single per-cycle compare process, sampling 1 time unit after each rising edge.
    initial begin
        logic [6:0] got, ex;
        forever begin
            @(posedge clock);
            #1;
            if (chk_on) begin
                got = {db_estado, busy, echo, pronto, rejeitado};
                ex  = expect_at(cyc);
                n_cmp++;
                if (got !== ex) begin
                    n_bad++;
                    $display("FAIL outputs c=%0d got db=%0d busy=%b echo=%b pronto=%b rej=%b, expected db=%0d busy=%b echo=%b pronto=%b rej=%b",
                             cyc, got[6:4], got[3], got[2], got[1], got[0], ex[6:4], ex[3], ex[2], ex[1], ex[0]);
                end
                if (echo && !echo_q) rise_c = cyc;
                if (!echo && echo_q) fall_c = cyc;
                if (pronto) pr_c = cyc;
                if (rejeitado) rj_c = cyc;
                echo_q = echo;
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    task automatic start_ep(input int p, input int d, input bit en);
        int jit;
        @(negedge clock);
        distancia = 9'(d);
        enable    = en;
        trigger   = 1'b1;
        if (en) begin
            ep_valid = 1'b1; ep_r0 = cyc + 1; ep_f0 = BIG; ep_abort = BIG; ep_acc = 1'b0;
        end else begin
            ep_valid = 1'b0;
        end
        repeat (p) @(negedge clock);
        trigger = 1'b0;
        f0_last = cyc + 1;
        if (en) begin
            ep_f0  = cyc + 1;
            ep_acc = (p > THR);
            if (ep_acc) begin
                jit = 0;
`ifdef SENSOR_JITTER_EN
                jit    = int'(m_lfsr[2:0]);
                m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
                ep_wc = w_us(d, jit) * CPU;
            end
        end
    endtask

    task automatic finish_ep();
        if (ep_valid && ep_acc && ep_abort == BIG) wait_until(ep_f0 + 2 + NB + ep_wc + NH + 3);
        else wait_until(cyc + 6);
        enable = 1'b1;
    endtask

    initial begin
        int wlit[3];
        int p, d;
        bit en;
`ifdef SENSOR_JITTER_EN
        wlit = '{70, 64, 70};
`else
        wlit = '{60, 60, 60};
`endif
        reset = 1'b1; enable = 1'b1; trigger = 1'b0; distancia = 9'd0;
        repeat (3) @(negedge clock);
        chk_on = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // Three 10 cm measurements with a 12 us trigger; literal timings pin the model.
        for (int i = 0; i < 3; i++) begin
            start_ep(12 * CPU, 10, 1'b1);
            finish_ep();
            check("echo_latency", rise_c - f0_last, 42);
            check("echo_width", fall_c - rise_c, wlit[i]);
            check("pronto_gap", pr_c - fall_c, 60);
        end

        // Short trigger and the acceptance boundary.
        start_ep(THR / 2, 10, 1'b1);
        finish_ep();
        check("reject_latency", rj_c - f0_last, 2);
        start_ep(THR, 25, 1'b1);
        finish_ep();
        start_ep(THR + 1, 2, 1'b1);
        finish_ep();

        // Clamp and timeout distances.
        start_ep(THR + 2, 500, 1'b1);
        finish_ep();
        start_ep(THR + 2, 0, 1'b1);
        finish_ep();
        start_ep(THR + 2, 1, 1'b1);
        finish_ep();

        // distancia changed in BURST and a second trigger during ECHO are both ignored.
        start_ep(THR + 3, 30, 1'b1);
        wait_until(ep_f0 + 6);
        distancia = 9'd5;
        wait_until(ep_f0 + 2 + NB + 4);
        trigger = 1'b1;
        repeat (10) @(negedge clock);
        trigger = 1'b0;
        finish_ep();

        // Reset in the middle of ECHO, then a fresh measurement.
        start_ep(THR + 2, 20, 1'b1);
        wait_until(ep_f0 + 2 + NB + 5);
        reset    = 1'b1;
        ep_abort = cyc + 1;
`ifdef SENSOR_JITTER_EN
        m_lfsr = 8'hA5;
`endif
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        start_ep(12 * CPU, 10, 1'b1);
        finish_ep();

        // Trigger while disabled is ignored.
        start_ep(THR + 4, 10, 1'b0);
        finish_ep();

        // Randomized measurements.
        for (int i = 0; i < 14; i++) begin
            p  = int'($urandom_range(1, 2 * THR + 4));
            d  = int'($urandom_range(0, 511));
            en = ($urandom_range(0, 7) != 0);
            start_ep(p, d, en);
            finish_ep();
        end

        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
